// File: rtl/vend_controller.sv
// Front-panel sequencer for the vending credit FSM: coin pulse trains,
// price-gated selection, dispense-motor handshake and refunds.
module vend_controller #(
    parameter int PRICE         = 3,
    parameter int MAX_CREDIT    = 5,
    parameter int MOTOR_TIMEOUT = 1000,
    parameter int TW            = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [2:0] coin_value,
    output logic       coin_ready,
    input  logic       sel_req,
    output logic       sel_ack,
    output logic       sel_deny,
    input  logic [2:0] credit,
    input  logic       fsm_dispense,
    output logic       m_out,
    output logic       a_out,
    output logic       motor_on,
    input  logic       motor_done,
    output logic       refund_valid,
    output logic [2:0] refund_units,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        GAP,
        SEL,
        VEND,
        FAULT
    } state_t;

    localparam logic [2:0]    PRICE_C = 3'(PRICE);
    localparam logic [2:0]    MAX_C   = 3'(MAX_CREDIT);
    localparam logic [TW-1:0] TLAST   = TW'(MOTOR_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [2:0]    pend_q, pend_d;
    logic [2:0]    change_q, change_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          deny_q, deny_d;
    logic          ack_q, ack_d;
    logic          rv_q, rv_d;
    logic [2:0]    ru_q, ru_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            change_q <= '0;
            timer_q  <= '0;
            deny_q   <= 1'b0;
            ack_q    <= 1'b0;
            rv_q     <= 1'b0;
            ru_q     <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            change_q <= change_d;
            timer_q  <= timer_d;
            deny_q   <= deny_d;
            ack_q    <= ack_d;
            rv_q     <= rv_d;
            ru_q     <= ru_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        change_d = change_q;
        timer_d  = timer_q;
        deny_d   = 1'b0;
        ack_d    = 1'b0;
        rv_d     = 1'b0;
        ru_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (coin_valid) begin
                    if (coin_value != 3'd0) begin
                        pend_d  = coin_value;
                        state_d = FEED;
                    end
                // a request still held during its own ack/deny pulse is not re-served
                end else if (sel_req && !deny_q && !ack_q) begin
                    if (credit < PRICE_C) begin
                        deny_d = 1'b1;
                    end else begin
                        change_d = credit - PRICE_C;
                        state_d  = SEL;
                    end
                end
            end
            FEED: begin
                if (credit < MAX_C) begin
                    pend_d  = pend_q - 3'd1;
                    state_d = (pend_q == 3'd1) ? IDLE : GAP;
                end else begin
                    rv_d    = 1'b1;
                    ru_d    = pend_q;
                    pend_d  = '0;
                    state_d = IDLE;
                end
            end
            GAP: begin
                state_d = (pend_q != 3'd0) ? FEED : IDLE;
            end
            SEL: begin
                timer_d = '0;
                state_d = fsm_dispense ? VEND : FAULT;
            end
            VEND: begin
                timer_d = timer_q + 1'b1;
                if (motor_done) begin
                    ack_d   = 1'b1;
                    rv_d    = (change_q != 3'd0);
                    ru_d    = change_q;
                    state_d = IDLE;
                end else if (timer_q == TLAST) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    assign coin_ready   = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign fault        = (state_q == FAULT);
    assign m_out        = (state_q == FEED) && (credit < MAX_C);
    assign a_out        = (state_q == SEL);
    assign motor_on     = (state_q == VEND);
    assign sel_deny     = deny_q;
    assign sel_ack      = ack_q;
    assign refund_valid = rv_q;
    assign refund_units = ru_q;

endmodule
